reg_counter_n: RTL and testbench

Parametrised general-purpose register for the 19-bit CPU datapath, successor to the fixed 19-bit load/increment/clear register. Adds width and step parameters, decrement, left/right shift with serial in/out, zero and overflow flags, and an asynchronous active-low reset alongside the synchronous clear. It serves as the PC, address and loop-counter registers.

---
 rtl/reg_counter_n.sv | 88 ++++++++
 tb/tb_reg_counter_n.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_counter_n.sv
// reg_counter_n: parametrised datapath register with load, step count, serial shift, zero and overflow flags.
// Build option REG_COUNTER_SATURATE_EN clamps overflowing INC/DEC instead of wrapping modulo 2^WIDTH.
module reg_counter_n #(
   parameter int unsigned      WIDTH     = 19,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int unsigned      STEP      = 1
) (
   input  logic             CLK,
   input  logic             CLR_N,
   input  logic             CLR,
   input  logic             LOAD,
   input  logic             INC,
   input  logic             DEC,
   input  logic             SHL,
   input  logic             SHR,
   input  logic             SIN,
   input  logic [WIDTH-1:0] inpData,
   output logic [WIDTH-1:0] opData,
   output logic             ZERO,
   output logic             OVF,
   output logic             SOUT
);

   localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

   logic [WIDTH-1:0] data_q, data_d;
   logic             ovf_q, ovf_d;
   logic             sout_q, sout_d;
   logic [WIDTH:0]   sum_ext, diff_ext;

   // Both operands are below 2^WIDTH, so bit WIDTH of the difference is the borrow (data_q < STEP).
   assign sum_ext  = {1'b0, data_q} + STEP_X;
   assign diff_ext = {1'b0, data_q} - STEP_X;

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path can infer a latch.
      data_d = data_q;
      ovf_d  = 1'b0;
      sout_d = sout_q;
      if (CLR) begin
         data_d = RESET_VAL;
         sout_d = 1'b0;
      end else if (LOAD) begin
         data_d = inpData;
      end else if (INC || DEC) begin
         if (INC && !DEC) begin
            ovf_d = sum_ext[WIDTH];
`ifdef REG_COUNTER_SATURATE_EN
            data_d = sum_ext[WIDTH] ? '1 : sum_ext[WIDTH-1:0];
`else
            data_d = sum_ext[WIDTH-1:0];
`endif
         end else if (DEC && !INC) begin
            ovf_d = diff_ext[WIDTH];
`ifdef REG_COUNTER_SATURATE_EN
            data_d = diff_ext[WIDTH] ? '0 : diff_ext[WIDTH-1:0];
`else
            data_d = diff_ext[WIDTH-1:0];
`endif
         end
      end else if (SHL && !SHR) begin
         data_d = {data_q[WIDTH-2:0], SIN};
         sout_d = data_q[WIDTH-1];
      end else if (SHR && !SHL) begin
         data_d = {SIN, data_q[WIDTH-1:1]};
         sout_d = data_q[0];
      end
   end

   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         data_q <= RESET_VAL;
         ovf_q  <= 1'b0;
         sout_q <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
         data_q <= data_d;
         ovf_q  <= ovf_d;
         sout_q <= sout_d;
      end
   end

   assign opData = data_q;
   assign ZERO   = (data_q == '0);
   assign OVF    = ovf_q;
   assign SOUT   = sout_q;

endmodule

// File: tb/tb_reg_counter_n.sv
// tb_reg_counter_n: scoreboard bench for two reg_counter_n instances (STEP=1/RESET_VAL=0 and STEP=4/RESET_VAL=0x100).
// Honours REG_COUNTER_SATURATE_EN in its reference model so it matches either build.
module tb_reg_counter_n;

   localparam int     W     = 19;
   localparam longint LIM   = longint'(1) << W;
   localparam longint MAX   = LIM - 1;
   localparam longint STEP_A = 1;
   localparam longint RV_A   = 0;
   localparam longint STEP_B = 4;
   localparam longint RV_B   = 'h00100;
`ifdef REG_COUNTER_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   typedef struct {
      bit     clr, load, inc, dec, shl, shr, sin;
      longint data;
   } cmd_t;

   typedef struct {
      longint d;
      bit     o;
      bit     s;
   } st_t;

   typedef struct {
      st_t a;
      st_t b;
   } exp_t;

   logic         CLK = 1'b0;
   logic         CLR_N = 1'b1;
   logic         CLR, LOAD, INC, DEC, SHL, SHR, SIN;
   logic [W-1:0] inpData;
   logic [W-1:0] op_a, op_b;
   logic         zero_a, ovf_a, sout_a, zero_b, ovf_b, sout_b;

   exp_t sb_q[$];
   exp_t mon_e;
   st_t  m_a, m_b;
   int   n_pass = 0;
   int   n_checks = 0;

   always #5 CLK = ~CLK;

   reg_counter_n #(.WIDTH(W), .RESET_VAL(19'(RV_A)), .STEP(32'(STEP_A))) dut_a (
      .CLK(CLK), .CLR_N(CLR_N), .CLR(CLR), .LOAD(LOAD), .INC(INC), .DEC(DEC),
      .SHL(SHL), .SHR(SHR), .SIN(SIN), .inpData(inpData),
      .opData(op_a), .ZERO(zero_a), .OVF(ovf_a), .SOUT(sout_a)
   );

   reg_counter_n #(.WIDTH(W), .RESET_VAL(19'(RV_B)), .STEP(32'(STEP_B))) dut_b (
      .CLK(CLK), .CLR_N(CLR_N), .CLR(CLR), .LOAD(LOAD), .INC(INC), .DEC(DEC),
      .SHL(SHL), .SHR(SHR), .SIN(SIN), .inpData(inpData),
      .opData(op_b), .ZERO(zero_b), .OVF(ovf_b), .SOUT(sout_b)
   );

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference behaviour written as plain integer arithmetic on the register value.
   function automatic st_t next_state(st_t cur, cmd_t c, longint step, longint rv);
      st_t n;
      n   = cur;
      n.o = 1'b0;
      if (c.clr) begin
         n.d = rv;
         n.s = 1'b0;
      end else if (c.load) begin
         n.d = c.data;
      end else if (c.inc && !c.dec) begin
         if (cur.d + step >= LIM) begin
            n.o = 1'b1;
            n.d = SAT ? MAX : cur.d + step - LIM;
         end else n.d = cur.d + step;
      end else if (c.dec && !c.inc) begin
         if (cur.d < step) begin
            n.o = 1'b1;
            n.d = SAT ? 0 : cur.d - step + LIM;
         end else n.d = cur.d - step;
      end else if (!c.inc && !c.dec) begin
         if (c.shl && !c.shr) begin
            n.s = (cur.d >= LIM / 2);
            n.d = (cur.d * 2 + longint'(c.sin)) % LIM;
         end else if (c.shr && !c.shl) begin
            n.s = bit'(cur.d % 2);
            n.d = cur.d / 2 + (c.sin ? LIM / 2 : 0);
         end
      end
      return n;
   endfunction

   function automatic cmd_t mk(bit clr, bit load, bit inc, bit dec, bit shl, bit shr, bit sin, longint data);
      cmd_t c;
      c.clr = clr; c.load = load; c.inc = inc; c.dec = dec;
      c.shl = shl; c.shr = shr; c.sin = sin; c.data = data;
      return c;
   endfunction

   task automatic drive(input cmd_t c);
      CLR = c.clr; LOAD = c.load; INC = c.inc; DEC = c.dec;
      SHL = c.shl; SHR = c.shr; SIN = c.sin; inpData = W'(c.data);
   endtask

   task automatic apply(input cmd_t c);
      exp_t e;
      @(negedge CLK);
      drive(c);
      m_a = next_state(m_a, c, STEP_A, RV_A);
      m_b = next_state(m_b, c, STEP_B, RV_B);
      e.a = m_a;
      e.b = m_b;
      sb_q.push_back(e);
   endtask

   // Checks dut_a against fixed values right after the edge that captures the last applied command.
   task automatic expect_a(input string name, input longint d, input longint o);
      @(posedge CLK);
      #2;
      check({name, "_data"}, op_a, d);
      check({name, "_ovf"}, ovf_a, o);
   endtask

   // Mid-cycle asynchronous reset with command c driven; state must not move while CLR_N is low.
   task automatic reset_mid(input cmd_t c);
      @(negedge CLK);
      drive(c);
      #2;
      CLR_N = 1'b0;
      #1;
      m_a = '{d: RV_A, o: 1'b0, s: 1'b0};
      m_b = '{d: RV_B, o: 1'b0, s: 1'b0};
      check("rst_a_data", op_a, RV_A);
      check("rst_a_zero", zero_a, 1);
      check("rst_a_ovf", ovf_a, 0);
      check("rst_a_sout", sout_a, 0);
      check("rst_b_data", op_b, RV_B);
      check("rst_b_zero", zero_b, 0);
      @(negedge CLK);
      check("rst_hold_a", op_a, RV_A);
      check("rst_hold_b", op_b, RV_B);
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
      CLR_N = 1'b1;
   endtask

   always @(posedge CLK) begin
      #1;
      if (sb_q.size() > 0) begin
         mon_e = sb_q.pop_front();
         check("sb_a_data", op_a, mon_e.a.d);
         check("sb_a_zero", zero_a, mon_e.a.d == 0);
         check("sb_a_ovf", ovf_a, mon_e.a.o);
         check("sb_a_sout", sout_a, mon_e.a.s);
         check("sb_b_data", op_b, mon_e.b.d);
         check("sb_b_zero", zero_b, mon_e.b.d == 0);
         check("sb_b_ovf", ovf_b, mon_e.b.o);
         check("sb_b_sout", sout_b, mon_e.b.s);
      end
   end

   initial begin
      cmd_t c;
      longint d;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
      m_a = '{d: RV_A, o: 1'b0, s: 1'b0};
      m_b = '{d: RV_B, o: 1'b0, s: 1'b0};
      #1 CLR_N = 1'b0;
      #1;
      check("init_a_data", op_a, RV_A);
      check("init_a_zero", zero_a, 1);
      check("init_b_data", op_b, RV_B);
      @(negedge CLK);
      CLR_N = 1'b1;

      // Reset while holding 0x12345 with INC pending.
      apply(mk(0, 1, 0, 0, 0, 0, 0, 'h12345));
      reset_mid(mk(0, 0, 1, 0, 0, 0, 0, 0));

      // Reset while an overflow pulse is live.
      apply(mk(0, 1, 0, 0, 0, 0, 0, MAX));
      apply(mk(0, 0, 1, 0, 0, 0, 0, 0));
      expect_a("ovf_before_rst", SAT ? MAX : 0, 1);
      reset_mid(mk(0, 0, 1, 0, 0, 0, 0, 0));

      // Priority and conflicts.
      apply(mk(0, 1, 0, 0, 0, 0, 0, 'h00005));
      apply(mk(1, 1, 1, 0, 0, 0, 0, 'h2AAAA));
      expect_a("clr_prio", 0, 0);
      apply(mk(0, 1, 1, 0, 0, 0, 0, 'h2AAAA));
      expect_a("load_prio", 'h2AAAA, 0);
      apply(mk(0, 0, 1, 1, 0, 0, 0, 0));
      expect_a("inc_dec_hold", 'h2AAAA, 0);

      // Shifts.
      apply(mk(0, 1, 0, 0, 0, 0, 0, 'h40001));
      apply(mk(0, 0, 0, 0, 1, 0, 1, 0));
      expect_a("shl", 'h00003, 0);
      check("shl_sout", sout_a, 1);
      apply(mk(0, 0, 0, 0, 0, 1, 0, 0));
      expect_a("shr0", 'h00001, 0);
      check("shr0_sout", sout_a, 1);
      apply(mk(0, 0, 0, 0, 0, 1, 1, 0));
      expect_a("shr1", 'h40000, 0);
      check("shr1_sout", sout_a, 1);
      apply(mk(0, 0, 1, 1, 1, 0, 0, 0));
      expect_a("inc_dec_shl", 'h40000, 0);
      check("inc_dec_shl_sout", sout_a, 1);
      apply(mk(0, 0, 0, 0, 1, 1, 0, 0));
      expect_a("shl_shr_hold", 'h40000, 0);
      check("shl_shr_sout", sout_a, 1);

      // Boundaries: wrap or clamp, one-cycle OVF pulse.
      apply(mk(0, 1, 0, 0, 0, 0, 0, MAX));
      apply(mk(0, 0, 1, 0, 0, 0, 0, 0));
      expect_a("inc_top", SAT ? MAX : 0, 1);
      check("inc_top_zero", zero_a, SAT ? 0 : 1);
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0));
      expect_a("ovf_one_cycle", SAT ? MAX : 0, 0);
      apply(mk(0, 1, 0, 0, 0, 0, 0, 0));
      apply(mk(0, 0, 0, 1, 0, 0, 0, 0));
      expect_a("dec_bottom", SAT ? 0 : MAX, 1);
      apply(mk(0, 1, 0, 0, 0, 0, 0, 'h00010));
      apply(mk(0, 0, 1, 0, 0, 0, 0, 0));
      expect_a("inc_mid", 'h00011, 0);
      apply(mk(0, 1, 0, 0, 0, 0, 0, 'h7FFFE));
      apply(mk(0, 0, 1, 0, 0, 0, 0, 0));
      @(posedge CLK);
      #2;
      check("step4_data", op_b, SAT ? MAX : 'h00002);
      check("step4_ovf", ovf_b, 1);

      // Back-to-back increments then synchronous clear.
      apply(mk(0, 1, 0, 0, 0, 0, 0, 0));
      repeat (5) apply(mk(0, 0, 1, 0, 0, 0, 0, 0));
      expect_a("b2b_inc", 'h00005, 0);
      apply(mk(0, 0, 0, 0, 1, 0, 1, 0));
      apply(mk(1, 0, 0, 0, 0, 0, 0, 0));
      expect_a("sync_clr", RV_A, 0);
      check("sync_clr_sout", sout_a, 0);
      check("sync_clr_b", op_b, RV_B);

      // Randomised traffic with occasional asynchronous resets.
      for (int i = 0; i < 600; i++) begin
         case ($urandom_range(3))
            0:       d = 0;
            1:       d = MAX - $urandom_range(3);
            2:       d = $urandom_range(7);
            default: d = $urandom_range(32'(MAX));
         endcase
         c = mk($urandom_range(15) == 0, $urandom_range(4) == 0, $urandom_range(2) == 0,
                $urandom_range(2) == 0, $urandom_range(2) == 0, $urandom_range(2) == 0,
                1'($urandom_range(1)), d);
         if (i % 97 == 50) reset_mid(c);
         else apply(c);
      end

      repeat (2) @(posedge CLK);
      #2;
      check("sb_drained", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
